// File: rtl/sweep_err_checker_if.sv
// Bus between the sweep/error checker and the emulated DUT plus its reference model.
// The checker connects through the master modport; the DUT/reference side uses the slave modport.
interface sweep_err_checker_if #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 2,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
);
  logic                    start;
  logic [WIDTH-1:0]        stim_o;
  logic [N_CH*WIDTH-1:0]   out_i;
  logic [N_CH*WIDTH-1:0]   expct_i;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [CNT_W-1:0]        n_samp;
  logic [N_CH*ACC_W-1:0]   err_acc;
  logic [N_CH-1:0]         sat;

  modport master (
    input  start, out_i, expct_i,
    output stim_o, busy, done, pass, n_samp, err_acc, sat
  );

  modport slave (
    output start, out_i, expct_i,
    input  stim_o, busy, done, pass, n_samp, err_acc, sat
  );
endinterface

// File: rtl/sweep_err_checker.sv
// Stimulus sweep (ramp or triangle) with per-point settle, per-channel squared-error accumulation
// and a final mean-square pass/fail verdict.
module sweep_err_checker #(
  parameter int                      WIDTH    = 16,
  parameter int                      N_CH     = 2,
  parameter int                      ACC_W    = 48,
  parameter int                      CNT_W    = 16,
  parameter logic signed [WIDTH-1:0] START    = -16'sd3860,
  parameter logic signed [WIDTH-1:0] STOP     = 16'sd3860,
  parameter logic signed [WIDTH-1:0] STEP     = 16'sd64,
  parameter int                      RST_WAIT = 1000,
  parameter int                      SETTLE   = 100,
  parameter int                      MODE     = 0,
  parameter int                      TOL_SQ   = 4
) (
  input  logic                  emu_clk,
  input  logic                  emu_rst,
  sweep_err_checker_if.master   bus
);

  typedef enum logic [2:0] {S_IDLE, S_RWAIT, S_SETTLE, S_SAMPLE, S_ADV, S_FIN} state_t;

  localparam int SQ_W  = 2*WIDTH + 2;
  localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam int PW    = ACC_W + CNT_W;
  localparam int TMAX  = (RST_WAIT > SETTLE) ? RST_WAIT : SETTLE;
  localparam int TW    = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic signed [WIDTH:0] START_X = (WIDTH+1)'(START);
  localparam logic signed [WIDTH:0] STOP_X  = (WIDTH+1)'(STOP);
  localparam logic signed [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);

  // Difference is taken one bit wider than the operands, so the square can never overflow.
  function automatic logic [SQ_W-1:0] sq_err(input logic signed [WIDTH-1:0] e,
                                             input logic signed [WIDTH-1:0] o);
    logic signed [WIDTH:0]  d;
    logic signed [SQ_W-1:0] p;
    d = (WIDTH+1)'(e) - (WIDTH+1)'(o);
    p = d * d;
    return p;
  endfunction

  // Returns {saturated, new_acc}; the accumulator clamps at all-ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [SQ_W-1:0]  sq);
    logic [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(sq);
    if (|s[SUM_W-1:ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  state_t                         state_q;
  logic signed [WIDTH-1:0]        stim_q;
  logic                           dir_up_q;
  logic [TW-1:0]                  cnt_q;
  logic                           busy_q, done_q, pass_q;
  logic [CNT_W-1:0]               n_samp_q;
  logic [N_CH-1:0][ACC_W-1:0]     acc_q;
  logic [N_CH-1:0]                sat_q;

  logic signed [WIDTH:0]          stim_x, up_d, dn_d;
  logic [ACC_W:0]                 sum_d [N_CH];
  logic                           pass_d;

  always_comb begin
    stim_x = (WIDTH+1)'(stim_q);
    up_d   = stim_x + STEP_X;
    dn_d   = stim_x - STEP_X;
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      sum_d[k] = sat_add(acc_q[k], sq_err(bus.expct_i[k*WIDTH +: WIDTH],
                                          bus.out_i[k*WIDTH +: WIDTH]));
    end
  end

  // Tolerance scales with the sample count, evaluated wide enough that the product cannot wrap.
  always_comb begin
    pass_d = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (sat_q[k] || (PW'(acc_q[k]) > PW'(TOL_SQ) * PW'(n_samp_q))) pass_d = 1'b0;
    end
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q  <= S_IDLE;
      stim_q   <= START;
      dir_up_q <= 1'b1;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      n_samp_q <= '0;
      acc_q    <= '0;
      sat_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            stim_q   <= START;
            dir_up_q <= 1'b1;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            n_samp_q <= '0;
            acc_q    <= '0;
            sat_q    <= '0;
            state_q  <= (RST_WAIT == 0) ? S_SETTLE : S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (cnt_q == TW'(RST_WAIT - 1)) begin
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == TW'(SETTLE - 1)) begin
            cnt_q   <= '0;
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          for (int k = 0; k < N_CH; k++) begin
            acc_q[k] <= sum_d[k][ACC_W-1:0];
            sat_q[k] <= sat_q[k] | sum_d[k][ACC_W];
          end
          if (!(&n_samp_q)) n_samp_q <= n_samp_q + 1'b1;
          state_q <= S_ADV;
        end
        S_ADV: begin
          // A failed up step in triangle mode turns around immediately, so the peak is not repeated.
          if (dir_up_q && (up_d <= STOP_X)) begin
            stim_q  <= up_d[WIDTH-1:0];
            state_q <= S_SETTLE;
          end else if ((!dir_up_q || (MODE == 1)) && (dn_d >= START_X)) begin
            dir_up_q <= 1'b0;
            stim_q   <= dn_d[WIDTH-1:0];
            state_q  <= S_SETTLE;
          end else begin
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= pass_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stim_o  = stim_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.n_samp  = n_samp_q;
  assign bus.err_acc = acc_q;
  assign bus.sat     = sat_q;

endmodule

// File: tb/tb_sweep_err_checker.sv
// Directed bench for sweep_err_checker: several parameterisations share one clock and reset,
// each scenario task drives its instance and checks against hand-computed values.
module tb_sweep_err_checker;

  localparam int RW = 10;
  localparam int ST = 4;

  logic       emu_clk = 1'b0;
  logic       emu_rst = 1'b0;
  logic [4:0] start_v = '0;
  logic [4:0] done_v;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 emu_clk = ~emu_clk;

  sweep_err_checker_if #(.WIDTH(16), .N_CH(2), .ACC_W(48), .CNT_W(16)) ifa ();
  sweep_err_checker_if #(.WIDTH(16), .N_CH(2), .ACC_W(48), .CNT_W(16)) ifb ();
  sweep_err_checker_if #(.WIDTH(16), .N_CH(1), .ACC_W(48), .CNT_W(16)) ifc ();
  sweep_err_checker_if #(.WIDTH(8),  .N_CH(1), .ACC_W(16), .CNT_W(8))  ifd ();
  sweep_err_checker_if #(.WIDTH(16), .N_CH(1), .ACC_W(48), .CNT_W(16)) ife ();

  sweep_err_checker #(.WIDTH(16), .N_CH(2), .ACC_W(48), .CNT_W(16),
    .START(-16'sd256), .STOP(16'sd256), .STEP(16'sd64),
    .RST_WAIT(RW), .SETTLE(ST), .MODE(0), .TOL_SQ(4))
    u_a (.emu_clk(emu_clk), .emu_rst(emu_rst), .bus(ifa));

  sweep_err_checker #(.WIDTH(16), .N_CH(2), .ACC_W(48), .CNT_W(16),
    .START(-16'sd256), .STOP(16'sd256), .STEP(16'sd64),
    .RST_WAIT(RW), .SETTLE(ST), .MODE(0), .TOL_SQ(9))
    u_b (.emu_clk(emu_clk), .emu_rst(emu_rst), .bus(ifb));

  sweep_err_checker #(.WIDTH(16), .N_CH(1), .ACC_W(48), .CNT_W(16),
    .START(16'sd0), .STOP(16'sd200), .STEP(16'sd64),
    .RST_WAIT(RW), .SETTLE(ST), .MODE(1), .TOL_SQ(4))
    u_c (.emu_clk(emu_clk), .emu_rst(emu_rst), .bus(ifc));

  sweep_err_checker #(.WIDTH(8), .N_CH(1), .ACC_W(16), .CNT_W(8),
    .START(-8'sd4), .STOP(8'sd4), .STEP(8'sd4),
    .RST_WAIT(RW), .SETTLE(ST), .MODE(0), .TOL_SQ(4))
    u_d (.emu_clk(emu_clk), .emu_rst(emu_rst), .bus(ifd));

  sweep_err_checker #(.WIDTH(16), .N_CH(1), .ACC_W(48), .CNT_W(16),
    .START(16'sd100), .STOP(16'sd100), .STEP(16'sd64),
    .RST_WAIT(RW), .SETTLE(ST), .MODE(1), .TOL_SQ(4))
    u_e (.emu_clk(emu_clk), .emu_rst(emu_rst), .bus(ife));

  // Reference-model side: ch0 expects stim, ch1 expects -stim; offsets model DUT error.
  logic signed [15:0] sa, sb;
  logic signed [15:0] off_a = '0;
  logic signed [15:0] off_b = '0;
  assign sa = ifa.stim_o;
  assign sb = ifb.stim_o;
  assign ifa.expct_i = {-sa, sa};
  assign ifa.out_i   = {-sa + off_a, sa};
  assign ifb.expct_i = {-sb, sb};
  assign ifb.out_i   = {-sb + off_b, sb};
  assign ifc.expct_i = ifc.stim_o;
  assign ifc.out_i   = ifc.stim_o;
  assign ifd.expct_i = 8'h7f;
  assign ifd.out_i   = 8'h80;
  assign ife.expct_i = ife.stim_o;
  assign ife.out_i   = ife.stim_o;

  assign ifa.start = start_v[0];
  assign ifb.start = start_v[1];
  assign ifc.start = start_v[2];
  assign ifd.start = start_v[3];
  assign ife.start = start_v[4];
  assign done_v = {ife.done, ifd.done, ifc.done, ifb.done, ifa.done};

  // Records the stimulus value at each sample of the triangle instance.
  logic [15:0] c_q[$];
  logic [15:0] c_prev = '0;
  bit          c_saw200 = 1'b0;
  always @(negedge emu_clk) begin
    if (ifc.stim_o == 16'd200) c_saw200 <= 1'b1;
    if (ifc.n_samp != c_prev) begin
      if (ifc.n_samp != 0) c_q.push_back(ifc.stim_o);
      c_prev <= ifc.n_samp;
    end
  end

  // Pulses start, waits for done (bounded); optional extra start pulses land while busy and on FIN.
  task automatic run_sweep(input int idx, input bit pulses, output int cyc, output bit to);
    start_v[idx] = 1'b1;
    @(posedge emu_clk);
    cyc = 1;
    #1 start_v[idx] = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (pulses && ((cyc + 1 == 5) || (cyc + 1 == 30) || (cyc + 1 == 66))) start_v[idx] = 1'b1;
      @(posedge emu_clk);
      cyc++;
      #1 start_v[idx] = 1'b0;
      if (done_v[idx]) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    emu_rst = 1'b1;
    repeat (2) @(posedge emu_clk);
    #1;
    n_tests++; if (ifa.stim_o !== 16'hff00) begin n_fail++; $display("FAIL rst_stim got %0h want ff00", ifa.stim_o); end
    n_tests++; if ({ifa.busy, ifa.done, ifa.pass} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {ifa.busy, ifa.done, ifa.pass}); end
    n_tests++; if (ifa.n_samp !== 16'd0) begin n_fail++; $display("FAIL rst_nsamp got %0d want 0", ifa.n_samp); end
    n_tests++; if (ifa.err_acc !== 96'd0 || ifa.sat !== 2'b00) begin n_fail++; $display("FAIL rst_acc got %0h/%b want 0/00", ifa.err_acc, ifa.sat); end
    n_tests++; if (ife.stim_o !== 16'd100) begin n_fail++; $display("FAIL rst_stim_e got %0d want 100", ife.stim_o); end
    emu_rst = 1'b0;
  endtask

  task automatic test_ramp_ideal();
    int cyc; bit to;
    off_a = 16'sd0;
    run_sweep(0, 1'b0, cyc, to);
    n_tests++; if (to || cyc != 1 + RW + 9*(ST+2) + 1) begin n_fail++; $display("FAIL t1_latency got %0d (timeout %0d) want %0d", cyc, to, 1 + RW + 9*(ST+2) + 1); end
    n_tests++; if (ifa.n_samp !== 16'd9) begin n_fail++; $display("FAIL t1_nsamp got %0d want 9", ifa.n_samp); end
    n_tests++; if (ifa.err_acc !== 96'd0) begin n_fail++; $display("FAIL t1_acc got %0h want 0", ifa.err_acc); end
    n_tests++; if ({ifa.pass, ifa.busy} !== 2'b10) begin n_fail++; $display("FAIL t1_pass_busy got %b want 10", {ifa.pass, ifa.busy}); end
    n_tests++; if (ifa.stim_o !== 16'd256) begin n_fail++; $display("FAIL t1_final_stim got %0d want 256", $signed(ifa.stim_o)); end
  endtask

  task automatic test_offset_tol();
    int cyc; bit to;
    off_a = 16'sd3;
    off_b = 16'sd3;
    start_v[0] = 1'b1;
    @(posedge emu_clk);
    #1 start_v[0] = 1'b0;
    n_tests++; if ({ifa.done, ifa.pass, ifa.busy} !== 3'b001) begin n_fail++; $display("FAIL t2_restart_drop got %b want 001", {ifa.done, ifa.pass, ifa.busy}); end
    for (int i = 0; i < 2000 && !ifa.done; i++) begin
      @(posedge emu_clk); #1;
    end
    n_tests++; if (ifa.err_acc[95:48] !== 48'd81 || ifa.err_acc[47:0] !== 48'd0) begin n_fail++; $display("FAIL t2_acc got %0d/%0d want 81/0", ifa.err_acc[95:48], ifa.err_acc[47:0]); end
    n_tests++; if ({ifa.done, ifa.pass} !== 2'b10) begin n_fail++; $display("FAIL t2_tol4 done/pass got %b want 10", {ifa.done, ifa.pass}); end
    run_sweep(1, 1'b0, cyc, to);
    n_tests++; if (to || ifb.err_acc[95:48] !== 48'd81) begin n_fail++; $display("FAIL t2b_acc got %0d (timeout %0d) want 81", ifb.err_acc[95:48], to); end
    n_tests++; if (ifb.pass !== 1'b1) begin n_fail++; $display("FAIL t2b_tol9_pass got %b want 1", ifb.pass); end
  endtask

  task automatic test_triangle();
    int cyc; bit to;
    logic [15:0] exp_seq [7];
    exp_seq = '{16'd0, 16'd64, 16'd128, 16'd192, 16'd128, 16'd64, 16'd0};
    c_q.delete();
    run_sweep(2, 1'b0, cyc, to);
    n_tests++; if (to || cyc != 1 + RW + 7*(ST+2) + 1) begin n_fail++; $display("FAIL t3_latency got %0d (timeout %0d) want %0d", cyc, to, 1 + RW + 7*(ST+2) + 1); end
    n_tests++; if (ifc.n_samp !== 16'd7 || c_q.size() != 7) begin n_fail++; $display("FAIL t3_nsamp got %0d/%0d want 7", ifc.n_samp, c_q.size()); end
    for (int i = 0; i < 7 && i < c_q.size(); i++) begin
      n_tests++; if (c_q[i] !== exp_seq[i]) begin n_fail++; $display("FAIL t3_seq[%0d] got %0d want %0d", i, c_q[i], exp_seq[i]); end
    end
    n_tests++; if (c_saw200 !== 1'b0) begin n_fail++; $display("FAIL t3_no_stop got %b want 0", c_saw200); end
    n_tests++; if (ifc.pass !== 1'b1) begin n_fail++; $display("FAIL t3_pass got %b want 1", ifc.pass); end
  endtask

  task automatic test_saturation();
    bit seen = 1'b0;
    start_v[3] = 1'b1;
    @(posedge emu_clk);
    #1 start_v[3] = 1'b0;
    for (int i = 0; i < 2000 && !ifd.done; i++) begin
      if (!seen && ifd.n_samp == 8'd1) begin
        seen = 1'b1;
        n_tests++; if (ifd.err_acc !== 16'd65025 || ifd.sat !== 1'b0) begin n_fail++; $display("FAIL t4_first got %0d/%b want 65025/0", ifd.err_acc, ifd.sat); end
      end
      @(posedge emu_clk); #1;
    end
    n_tests++; if (!seen || !ifd.done) begin n_fail++; $display("FAIL t4_progress got seen=%b done=%b want 1/1", seen, ifd.done); end
    n_tests++; if (ifd.err_acc !== 16'hffff || ifd.sat !== 1'b1) begin n_fail++; $display("FAIL t4_sat got %0d/%b want 65535/1", ifd.err_acc, ifd.sat); end
    n_tests++; if (ifd.pass !== 1'b0 || ifd.n_samp !== 8'd3) begin n_fail++; $display("FAIL t4_pass_n got %b/%0d want 0/3", ifd.pass, ifd.n_samp); end
  endtask

  task automatic test_abort_restart();
    int cyc; bit to; bit hit = 1'b0;
    off_a = 16'sd0;
    start_v[0] = 1'b1;
    @(posedge emu_clk);
    #1 start_v[0] = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ifa.n_samp == 16'd3 && ifa.stim_o == 16'hffc0) begin hit = 1'b1; break; end
      @(posedge emu_clk); #1;
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL t5_reach_pt4 got %b want 1", hit); end
    emu_rst = 1'b1;
    @(posedge emu_clk);
    #1 emu_rst = 1'b0;
    n_tests++; if ({ifa.busy, ifa.done, ifa.pass} !== 3'b000 || ifa.stim_o !== 16'hff00) begin n_fail++; $display("FAIL t5_abort got %b stim %0h want 000 ff00", {ifa.busy, ifa.done, ifa.pass}, ifa.stim_o); end
    n_tests++; if (ifa.n_samp !== 16'd0 || ifa.err_acc !== 96'd0) begin n_fail++; $display("FAIL t5_abort_res got %0d/%0h want 0/0", ifa.n_samp, ifa.err_acc); end
    run_sweep(0, 1'b1, cyc, to);
    n_tests++; if (to || cyc != 66) begin n_fail++; $display("FAIL t5_latency got %0d (timeout %0d) want 66", cyc, to); end
    n_tests++; if (ifa.n_samp !== 16'd9 || ifa.err_acc !== 96'd0 || ifa.pass !== 1'b1) begin n_fail++; $display("FAIL t5_rerun got %0d/%0h/%b want 9/0/1", ifa.n_samp, ifa.err_acc, ifa.pass); end
    repeat (3) @(posedge emu_clk);
    #1;
    n_tests++; if ({ifa.done, ifa.busy} !== 2'b10) begin n_fail++; $display("FAIL t5_fin_start_ignored got %b want 10", {ifa.done, ifa.busy}); end
  endtask

  task automatic test_single_point();
    int cyc; bit to;
    run_sweep(4, 1'b0, cyc, to);
    n_tests++; if (to || cyc != 1 + RW + (ST+2) + 1) begin n_fail++; $display("FAIL t6_latency got %0d (timeout %0d) want %0d", cyc, to, 1 + RW + (ST+2) + 1); end
    n_tests++; if (ife.n_samp !== 16'd1 || ife.stim_o !== 16'd100 || ife.pass !== 1'b1) begin n_fail++; $display("FAIL t6_result got %0d/%0d/%b want 1/100/1", ife.n_samp, ife.stim_o, ife.pass); end
  endtask

  initial begin
    test_reset();
    test_ramp_ideal();
    test_offset_tol();
    test_triangle();
    test_saturation();
    test_abort_restart();
    test_single_point();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
